// File: rtl/hydra_pkt_gen_pkg.sv
// hydra_pkt_gen_pkg
// Shared definitions for the hydra packet generator: the lane state
// encoding, traffic mode codes, default header field widths and the
// per-lane LFSR polynomial with its single-step helper.
package hydra_pkt_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SOP,
        ST_HDR,
        ST_PAY,
        ST_EOP,
        ST_GAP
    } lane_state_t;

    localparam logic [1:0] MODE_FIXED    = 2'd0;
    localparam logic [1:0] MODE_INC_DEST = 2'd1;
    localparam logic [1:0] MODE_RAND_LEN = 2'd2;

    localparam int DEF_LEN_WIDTH  = 9;
    localparam int DEF_PRIO_WIDTH = 3;
    localparam int DEF_DEST_WIDTH = 4;

    // 16-bit Fibonacci LFSR, taps 16,14,13,11 (bit positions 15,13,12,10).
    localparam int              LFSR_WIDTH = 16;
    localparam logic [15:0]     LFSR_TAPS  = 16'hB400;

    function automatic logic [LFSR_WIDTH-1:0] lfsr_step(input logic [LFSR_WIDTH-1:0] cur);
        return {cur[LFSR_WIDTH-2:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/hydra_pkt_gen_lane.sv
// hydra_pkt_gen_lane
// One generator lane: emits pkt_num packets framed as
// SOP / header / payload / EOP / gap on one hydra write port.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start_run, has_work run launch pulse and whether this lane takes part
//   cfg_*               run configuration, already latched by the top
//   pause               stall request from the switch port
//   wr_sop/eop/vld/data registered framing and data for this port
//   lane_done           sticky completion flag for this run
//   idle_next           lane will be IDLE in the next cycle (for run-end)
module hydra_pkt_gen_lane
    import hydra_pkt_gen_pkg::*;
#(
    parameter int LANE_IDX   = 0,
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
    parameter int PRIO_WIDTH = DEF_PRIO_WIDTH,
    parameter int DEST_WIDTH = DEF_DEST_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_run,
    input  logic                  has_work,
    input  logic [1:0]            cfg_mode,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    input  logic [PRIO_WIDTH-1:0] cfg_prio,
    input  logic [DEST_WIDTH-1:0] cfg_dest,
    input  logic [7:0]            cfg_gap,
    input  logic [15:0]           cfg_pkt_num,
    input  logic                  pause,
    output logic                  wr_sop,
    output logic                  wr_eop,
    output logic                  wr_vld,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  lane_done,
    output logic                  idle_next
);

    localparam logic [LEN_WIDTH-1:0]  LEN_ONE   = LEN_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] DATA_ONE  = DATA_WIDTH'(1);
    localparam logic [LFSR_WIDTH-1:0] LFSR_SEED = LFSR_WIDTH'(LANE_IDX + 1);

    lane_state_t           state, state_nxt;
    logic [DATA_WIDTH-1:0] seq, seq_nxt, data_nxt;
    logic [LFSR_WIDTH-1:0] lfsr, lfsr_nxt;
    logic [15:0]           pkt_idx, pkt_idx_nxt;
    logic [7:0]            gap_cnt, gap_nxt;
    logic [LEN_WIDTH-1:0]  words_left, left_nxt, cur_len, len_nxt;
    logic                  sop_nxt, eop_nxt, vld_nxt, done_nxt;

    logic [1:0]            mode_eff;
    logic [LEN_WIDTH-1:0]  len_base, len_rand, len_sel;
    logic [DEST_WIDTH-1:0] hdr_dest;
    logic [DATA_WIDTH-1:0] header;

    // Header fields for the packet about to start. The LFSR has already been
    // stepped on entry to SOP, so random lengths use the freshly stepped value.
    always_comb begin
        mode_eff = (cfg_mode == MODE_INC_DEST || cfg_mode == MODE_RAND_LEN) ? cfg_mode : MODE_FIXED;
        len_base = (cfg_len == '0) ? LEN_ONE : cfg_len;
        len_rand = lfsr[LEN_WIDTH-1:0];
        if (len_rand == '0) begin
            len_rand = LEN_ONE;
        end
        len_sel  = len_base;
        if (mode_eff == MODE_RAND_LEN && len_rand < len_base) begin
            len_sel = len_rand;
        end
        hdr_dest = cfg_dest;
        if (mode_eff == MODE_INC_DEST) begin
            hdr_dest = cfg_dest + pkt_idx[DEST_WIDTH-1:0];
        end
        header = DATA_WIDTH'({len_sel, cfg_prio, hdr_dest});
    end

    // Next-state and next-output logic. A header or payload word counts as
    // emitted only in a cycle where wr_vld was high; otherwise it is re-presented
    // with wr_vld recomputed from the current pause request.
    always_comb begin
        state_nxt   = state;
        seq_nxt     = seq;
        lfsr_nxt    = lfsr;
        pkt_idx_nxt = pkt_idx;
        gap_nxt     = gap_cnt;
        left_nxt    = words_left;
        len_nxt     = cur_len;
        done_nxt    = lane_done;
        sop_nxt     = 1'b0;
        eop_nxt     = 1'b0;
        vld_nxt     = 1'b0;
        data_nxt    = '0;

        if (start_run) begin
            seq_nxt     = '0;
            lfsr_nxt    = LFSR_SEED;
            pkt_idx_nxt = '0;
            gap_nxt     = '0;
            done_nxt    = ~has_work;
            if (has_work) begin
                if (pause) begin
                    // Wait in GAP with an empty count until pause drops.
                    state_nxt = ST_GAP;
                end else begin
                    state_nxt = ST_SOP;
                    sop_nxt   = 1'b1;
                    lfsr_nxt  = lfsr_step(LFSR_SEED);
                end
            end
        end else begin
            case (state)
                ST_IDLE: begin
                end
                ST_GAP: begin
                    if (gap_cnt != 8'd0) begin
                        gap_nxt = gap_cnt - 8'd1;
                    end else if (!pause) begin
                        state_nxt = ST_SOP;
                        sop_nxt   = 1'b1;
                        lfsr_nxt  = lfsr_step(lfsr);
                    end
                end
                ST_SOP: begin
                    state_nxt = ST_HDR;
                    len_nxt   = len_sel;
                    vld_nxt   = ~pause;
                    data_nxt  = header;
                end
                ST_HDR: begin
                    vld_nxt = ~pause;
                    if (wr_vld) begin
                        state_nxt = ST_PAY;
                        left_nxt  = cur_len - LEN_ONE;
                        data_nxt  = seq;
                    end else begin
                        data_nxt = wr_data;
                    end
                end
                ST_PAY: begin
                    if (wr_vld) begin
                        seq_nxt = seq + DATA_ONE;
                        if (words_left == '0) begin
                            state_nxt = ST_EOP;
                            eop_nxt   = 1'b1;
                        end else begin
                            left_nxt = words_left - LEN_ONE;
                            vld_nxt  = ~pause;
                            data_nxt = seq + DATA_ONE;
                        end
                    end else begin
                        vld_nxt  = ~pause;
                        data_nxt = wr_data;
                    end
                end
                ST_EOP: begin
                    pkt_idx_nxt = pkt_idx + 16'd1;
                    if (pkt_idx + 16'd1 == cfg_pkt_num) begin
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
                    end else if (cfg_gap != 8'd0) begin
                        state_nxt = ST_GAP;
                        gap_nxt   = cfg_gap - 8'd1;
                    end else if (!pause) begin
                        state_nxt = ST_SOP;
                        sop_nxt   = 1'b1;
                        lfsr_nxt  = lfsr_step(lfsr);
                    end else begin
                        state_nxt = ST_GAP;
                        gap_nxt   = 8'd0;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign idle_next = (state_nxt == ST_IDLE);

    // State, counters and all port outputs are flopped together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            seq        <= '0;
            lfsr       <= LFSR_SEED;
            pkt_idx    <= '0;
            gap_cnt    <= '0;
            words_left <= '0;
            cur_len    <= '0;
            lane_done  <= 1'b0;
            wr_sop     <= 1'b0;
            wr_eop     <= 1'b0;
            wr_vld     <= 1'b0;
            wr_data    <= '0;
        end else begin
            state      <= state_nxt;
            seq        <= seq_nxt;
            lfsr       <= lfsr_nxt;
            pkt_idx    <= pkt_idx_nxt;
            gap_cnt    <= gap_nxt;
            words_left <= left_nxt;
            cur_len    <= len_nxt;
            lane_done  <= done_nxt;
            wr_sop     <= sop_nxt;
            wr_eop     <= eop_nxt;
            wr_vld     <= vld_nxt;
            wr_data    <= data_nxt;
        end
    end

endmodule

// File: rtl/hydra_pkt_gen.sv
// hydra_pkt_gen
// Multi-port packet generator for the hydra switch write side. Latches the
// run configuration on start, runs PORT_NUM independent lanes and reports
// run progress. DATA_WIDTH must be at least LEN_WIDTH+PRIO_WIDTH+DEST_WIDTH.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start                      launch pulse (ignored while busy)
//   lane_en, mode, cfg_*       run configuration, latched on start
//   pkt_num                    packets per enabled lane
//   pause                      per-lane stall request
//   wr_sop/eop/vld, wr_data    per-lane framing and data
//   lane_done                  sticky per-lane completion
//   busy, done                 run in progress, one-cycle run-end pulse
module hydra_pkt_gen
    import hydra_pkt_gen_pkg::*;
#(
    parameter int PORT_NUM   = 16,
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
    parameter int PRIO_WIDTH = DEF_PRIO_WIDTH,
    parameter int DEST_WIDTH = DEF_DEST_WIDTH
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic [PORT_NUM-1:0]                 lane_en,
    input  logic [1:0]                          mode,
    input  logic [LEN_WIDTH-1:0]                cfg_len,
    input  logic [PRIO_WIDTH-1:0]               cfg_prio,
    input  logic [DEST_WIDTH-1:0]               cfg_dest,
    input  logic [7:0]                          cfg_gap,
    input  logic [15:0]                         pkt_num,
    input  logic [PORT_NUM-1:0]                 pause,
    output logic [PORT_NUM-1:0]                 wr_sop,
    output logic [PORT_NUM-1:0]                 wr_eop,
    output logic [PORT_NUM-1:0]                 wr_vld,
    output logic [PORT_NUM-1:0][DATA_WIDTH-1:0] wr_data,
    output logic [PORT_NUM-1:0]                 lane_done,
    output logic                                busy,
    output logic                                done
);

    logic                  start_run;
    logic [PORT_NUM-1:0]   lane_work;
    logic [PORT_NUM-1:0]   idle_next;
    logic                  busy_nxt, done_nxt;

    logic [1:0]            mode_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [PRIO_WIDTH-1:0] prio_q;
    logic [DEST_WIDTH-1:0] dest_q;
    logic [7:0]            gap_q;
    logic [15:0]           pkt_num_q;

    assign start_run = start & ~busy;
    assign lane_work = lane_en & {PORT_NUM{pkt_num != 16'd0}};

    // Configuration is captured once per run so that lanes see stable
    // settings even if the host changes the inputs mid-run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= '0;
            len_q     <= '0;
            prio_q    <= '0;
            dest_q    <= '0;
            gap_q     <= '0;
            pkt_num_q <= '0;
        end else if (start_run) begin
            mode_q    <= mode;
            len_q     <= cfg_len;
            prio_q    <= cfg_prio;
            dest_q    <= cfg_dest;
            gap_q     <= cfg_gap;
            pkt_num_q <= pkt_num;
        end
    end

    for (genvar i = 0; i < PORT_NUM; i++) begin : g_lane
        hydra_pkt_gen_lane #(
            .LANE_IDX   (i),
            .DATA_WIDTH (DATA_WIDTH),
            .LEN_WIDTH  (LEN_WIDTH),
            .PRIO_WIDTH (PRIO_WIDTH),
            .DEST_WIDTH (DEST_WIDTH)
        ) u_lane (
            .clk         (clk),
            .rst_n       (rst_n),
            .start_run   (start_run),
            .has_work    (lane_work[i]),
            .cfg_mode    (mode_q),
            .cfg_len     (len_q),
            .cfg_prio    (prio_q),
            .cfg_dest    (dest_q),
            .cfg_gap     (gap_q),
            .cfg_pkt_num (pkt_num_q),
            .pause       (pause[i]),
            .wr_sop      (wr_sop[i]),
            .wr_eop      (wr_eop[i]),
            .wr_vld      (wr_vld[i]),
            .wr_data     (wr_data[i]),
            .lane_done   (lane_done[i]),
            .idle_next   (idle_next[i])
        );
    end

    // Run end is detected from the lanes' next state so that busy falls and
    // done pulses in the same cycle the last lane shows IDLE. A run with no
    // working lane never raises busy and reports done straight away.
    always_comb begin
        busy_nxt = busy;
        done_nxt = 1'b0;
        if (start_run) begin
            busy_nxt = |lane_work;
            done_nxt = ~(|lane_work);
        end else if (busy && (&idle_next)) begin
            busy_nxt = 1'b0;
            done_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busy_nxt;
            done <= done_nxt;
        end
    end

endmodule

// File: tb/tb_hydra_pkt_gen.sv
// tb_hydra_pkt_gen
// Directed bench for hydra_pkt_gen: a table of single-lane packets with
// hand-computed headers and payload, followed by hand-written sequences for
// multi-lane gaps, pause, incrementing destination, random length, reset
// mid-packet, empty runs and start while busy. Inputs change 1 time unit
// after a rising edge; outputs are sampled at that same point.
// Header packing with the default widths: len in [15:7], prio in [6:4],
// dest in [3:0].
module tb_hydra_pkt_gen;

    localparam int PN = 16;
    localparam int DW = 16;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  start;
    logic [PN-1:0]         lane_en;
    logic [1:0]            mode;
    logic [8:0]            cfg_len;
    logic [2:0]            cfg_prio;
    logic [3:0]            cfg_dest;
    logic [7:0]            cfg_gap;
    logic [15:0]           pkt_num;
    logic [PN-1:0]         pause;
    logic [PN-1:0]         wr_sop, wr_eop, wr_vld, lane_done;
    logic [PN-1:0][DW-1:0] wr_data;
    logic                  busy, done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]  mode;
        logic [8:0]  len;
        logic [2:0]  prio;
        logic [3:0]  dest;
        logic [15:0] exp_hdr;
        int          exp_words;
    } vec_t;

    vec_t        vecs[6];
    logic [15:0] c_hdrs[3];
    int          d_hlen[2], d_cnt[2], d_pkts[2];
    logic        d_exp_hdr[2];

    hydra_pkt_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .lane_en   (lane_en),
        .mode      (mode),
        .cfg_len   (cfg_len),
        .cfg_prio  (cfg_prio),
        .cfg_dest  (cfg_dest),
        .cfg_gap   (cfg_gap),
        .pkt_num   (pkt_num),
        .pause     (pause),
        .wr_sop    (wr_sop),
        .wr_eop    (wr_eop),
        .wr_vld    (wr_vld),
        .wr_data   (wr_data),
        .lane_done (lane_done),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Drive a configuration and pulse start for one cycle; returns in the
    // first cycle after start was sampled.
    task automatic applyStimulus(input logic [PN-1:0] en, input logic [1:0] md, input logic [8:0] ln,
                                 input logic [2:0] pr, input logic [3:0] ds, input logic [7:0] gp,
                                 input logic [15:0] pn);
        lane_en  = en;
        mode     = md;
        cfg_len  = ln;
        cfg_prio = pr;
        cfg_dest = ds;
        cfg_gap  = gp;
        pkt_num  = pn;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic waitDone(input string name, input int limit);
        int n = 0;
        while (done !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        checkOutput(name, {31'd0, done}, 32'd1);
        tick();
    endtask

    initial begin
        vecs[0] = '{2'd0, 9'd4, 3'd4, 4'd3,  16'h0243, 4};
        vecs[1] = '{2'd3, 9'd2, 3'd7, 4'hA,  16'h017A, 2};
        vecs[2] = '{2'd0, 9'd0, 3'd0, 4'd0,  16'h0080, 1};
        vecs[3] = '{2'd1, 9'd1, 3'd1, 4'd5,  16'h0095, 1};
        vecs[4] = '{2'd2, 9'd1, 3'd2, 4'd1,  16'h00A1, 1};
        vecs[5] = '{2'd0, 9'd9, 3'd0, 4'hF,  16'h048F, 9};
        c_hdrs[0] = 16'h008F;
        c_hdrs[1] = 16'h0080;
        c_hdrs[2] = 16'h0081;

        rst_n = 1'b0; start = 1'b0; lane_en = '0; mode = '0; cfg_len = '0;
        cfg_prio = '0; cfg_dest = '0; cfg_gap = '0; pkt_num = '0; pause = '0;
        tick();
        tick();
        checkOutput("rst_sop",  wr_sop, 0);
        checkOutput("rst_vld",  wr_vld, 0);
        checkOutput("rst_eop",  wr_eop, 0);
        checkOutput("rst_data", {31'd0, |wr_data}, 0);
        checkOutput("rst_busy", {31'd0, busy}, 0);
        checkOutput("rst_done", {31'd0, done}, 0);
        checkOutput("rst_lane_done", lane_done, 0);
        rst_n = 1'b1;
        tick();

        // Table-driven single-lane packets.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(16'h0001, vecs[i].mode, vecs[i].len, vecs[i].prio, vecs[i].dest, 8'd0, 16'd1);
            checkOutput($sformatf("v%0d_sop", i), {31'd0, wr_sop[0]}, 1);
            checkOutput($sformatf("v%0d_busy", i), {31'd0, busy}, 1);
            tick();
            checkOutput($sformatf("v%0d_hdr_vld", i), {31'd0, wr_vld[0]}, 1);
            checkOutput($sformatf("v%0d_hdr", i), wr_data[0], vecs[i].exp_hdr);
            for (int k = 0; k < vecs[i].exp_words; k++) begin
                tick();
                checkOutput($sformatf("v%0d_pay_vld%0d", i, k), {31'd0, wr_vld[0]}, 1);
                checkOutput($sformatf("v%0d_pay%0d", i, k), wr_data[0], k);
            end
            tick();
            checkOutput($sformatf("v%0d_eop", i), {31'd0, wr_eop[0]}, 1);
            checkOutput($sformatf("v%0d_eop_vld", i), {31'd0, wr_vld[0]}, 0);
            tick();
            checkOutput($sformatf("v%0d_done", i), {31'd0, done}, 1);
            checkOutput($sformatf("v%0d_busy_end", i), {31'd0, busy}, 0);
            checkOutput($sformatf("v%0d_lane_done", i), lane_done, 16'hFFFF);
            tick();
            checkOutput($sformatf("v%0d_done_pulse", i), {31'd0, done}, 0);
        end

        // Lanes 0-2, two packets each, len 2, gap 3.
        applyStimulus(16'h0007, 2'd0, 9'd2, 3'd0, 4'd0, 8'd3, 16'd2);
        checkOutput("A_lane_done_start", lane_done, 16'hFFF8);
        for (int c = 1; c <= 13; c++) begin
            if (c > 1) tick();
            for (int l = 0; l < 3; l++) begin
                logic ev;
                logic [15:0] ed;
                ev = (c == 2 || c == 3 || c == 4 || c == 10 || c == 11 || c == 12);
                ed = (c == 2 || c == 10) ? 16'h0100 : (c == 3) ? 16'd0 : (c == 4) ? 16'd1 : (c == 11) ? 16'd2 : 16'd3;
                checkOutput($sformatf("A_c%0d_l%0d_sop", c, l), {31'd0, wr_sop[l]}, {31'd0, (c == 1 || c == 9)});
                checkOutput($sformatf("A_c%0d_l%0d_eop", c, l), {31'd0, wr_eop[l]}, {31'd0, (c == 5 || c == 13)});
                checkOutput($sformatf("A_c%0d_l%0d_vld", c, l), {31'd0, wr_vld[l]}, {31'd0, ev});
                if (ev) checkOutput($sformatf("A_c%0d_l%0d_data", c, l), wr_data[l], ed);
            end
            checkOutput($sformatf("A_c%0d_other_vld", c), {16'd0, wr_vld[15:3], 3'd0}, 0);
        end
        tick();
        checkOutput("A_done", {31'd0, done}, 1);
        checkOutput("A_lane_done", lane_done, 16'hFFFF);
        tick();

        // Pause lane 0 for two cycles while payload word 1 is due.
        applyStimulus(16'h0001, 2'd0, 9'd4, 3'd4, 4'd3, 8'd0, 16'd1);
        tick();
        tick();
        checkOutput("B_w0", wr_data[0], 0);
        pause = 16'h0001;
        tick();
        checkOutput("B_stall1_vld", {31'd0, wr_vld[0]}, 0);
        tick();
        checkOutput("B_stall2_vld", {31'd0, wr_vld[0]}, 0);
        pause = '0;
        tick();
        checkOutput("B_resume_vld", {31'd0, wr_vld[0]}, 1);
        checkOutput("B_resume_data", wr_data[0], 1);
        tick();
        checkOutput("B_w2", wr_data[0], 2);
        checkOutput("B_no_early_eop", {31'd0, wr_eop[0]}, 0);
        tick();
        checkOutput("B_w3", wr_data[0], 3);
        tick();
        checkOutput("B_eop_late", {31'd0, wr_eop[0]}, 1);
        tick();
        checkOutput("B_done", {31'd0, done}, 1);
        tick();

        // Pause held at start: SOP waits until pause drops.
        pause = 16'h0001;
        applyStimulus(16'h0001, 2'd0, 9'd1, 3'd0, 4'd0, 8'd0, 16'd1);
        checkOutput("B2_no_sop", {31'd0, wr_sop[0]}, 0);
        checkOutput("B2_busy", {31'd0, busy}, 1);
        pause = '0;
        tick();
        checkOutput("B2_sop", {31'd0, wr_sop[0]}, 1);
        tick();
        checkOutput("B2_hdr", wr_data[0], 16'h0080);
        waitDone("B2_done", 20);

        // Incrementing destination wraps from 15 to 0.
        applyStimulus(16'h0001, 2'd1, 9'd1, 3'd0, 4'd15, 8'd0, 16'd3);
        for (int c = 1; c <= 12; c++) begin
            if (c > 1) tick();
            if (c == 2 || c == 6 || c == 10) begin
                checkOutput($sformatf("C_hdr_vld_c%0d", c), {31'd0, wr_vld[0]}, 1);
                checkOutput($sformatf("C_hdr_c%0d", c), wr_data[0], c_hdrs[(c - 2) / 4]);
            end
        end
        checkOutput("C_last_eop", {31'd0, wr_eop[0]}, 1);
        tick();
        checkOutput("C_done", {31'd0, done}, 1);
        tick();

        // Random length on lanes 0 and 1: lengths in 1..8 and match payload.
        for (int l = 0; l < 2; l++) begin
            d_hlen[l] = 0; d_cnt[l] = 0; d_pkts[l] = 0; d_exp_hdr[l] = 1'b0;
        end
        applyStimulus(16'h0003, 2'd2, 9'd8, 3'd0, 4'd0, 8'd1, 16'd4);
        begin
            int n = 0;
            while (done !== 1'b1 && n < 200) begin
                for (int l = 0; l < 2; l++) begin
                    if (wr_sop[l]) begin
                        d_exp_hdr[l] = 1'b1;
                    end else if (wr_vld[l] && d_exp_hdr[l]) begin
                        d_exp_hdr[l] = 1'b0;
                        d_hlen[l] = int'(wr_data[l][15:7]);
                        d_cnt[l] = 0;
                        checkOutput($sformatf("D_l%0d_len_range", l), {31'd0, (d_hlen[l] >= 1 && d_hlen[l] <= 8)}, 1);
                    end else if (wr_vld[l]) begin
                        d_cnt[l]++;
                    end else if (wr_eop[l]) begin
                        checkOutput($sformatf("D_l%0d_count", l), d_cnt[l], d_hlen[l]);
                        d_pkts[l]++;
                    end
                end
                tick();
                n++;
            end
        end
        checkOutput("D_done", {31'd0, done}, 1);
        checkOutput("D_l0_pkts", d_pkts[0], 4);
        checkOutput("D_l1_pkts", d_pkts[1], 4);
        tick();

        // Reset in the middle of the payload.
        applyStimulus(16'h0001, 2'd0, 9'd4, 3'd4, 4'd3, 8'd0, 16'd1);
        tick();
        tick();
        tick();
        checkOutput("E_pre_vld", {31'd0, wr_vld[0]}, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("E_rst_vld", wr_vld, 0);
        checkOutput("E_rst_data", {31'd0, |wr_data}, 0);
        checkOutput("E_rst_busy", {31'd0, busy}, 0);
        checkOutput("E_rst_lane_done", lane_done, 0);
        #1;
        rst_n = 1'b1;
        tick();
        tick();
        checkOutput("E_no_eop", wr_eop, 0);
        applyStimulus(16'h0001, 2'd0, 9'd4, 3'd4, 4'd3, 8'd0, 16'd1);
        checkOutput("E_sop", {31'd0, wr_sop[0]}, 1);
        tick();
        checkOutput("E_hdr", wr_data[0], 16'h0243);
        tick();
        checkOutput("E_seq_restart", wr_data[0], 0);
        waitDone("E_done", 20);

        // Runs with no work.
        applyStimulus(16'h0000, 2'd0, 9'd4, 3'd0, 4'd0, 8'd0, 16'd1);
        checkOutput("F_done", {31'd0, done}, 1);
        checkOutput("F_busy", {31'd0, busy}, 0);
        checkOutput("F_lane_done", lane_done, 16'hFFFF);
        tick();
        checkOutput("F_done_pulse", {31'd0, done}, 0);
        checkOutput("F_busy2", {31'd0, busy}, 0);
        applyStimulus(16'hFFFF, 2'd0, 9'd4, 3'd0, 4'd0, 8'd0, 16'd0);
        checkOutput("F0_done", {31'd0, done}, 1);
        checkOutput("F0_busy", {31'd0, busy}, 0);
        checkOutput("F0_vld", wr_vld, 0);
        tick();

        // Start while busy is ignored.
        applyStimulus(16'h0001, 2'd0, 9'd4, 3'd4, 4'd3, 8'd0, 16'd1);
        checkOutput("G_lane_done_clr", lane_done, 16'hFFFE);
        tick();
        lane_en = 16'hFFFF; cfg_len = 9'd1; cfg_dest = 4'd9; start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("G_w0", wr_data[0], 0);
        checkOutput("G_other_sop", {16'd0, wr_sop[15:1], 1'b0}, 0);
        tick();
        checkOutput("G_w1", wr_data[0], 1);
        checkOutput("G_other_vld", {16'd0, wr_vld[15:1], 1'b0}, 0);
        tick();
        tick();
        checkOutput("G_w3", wr_data[0], 3);
        tick();
        checkOutput("G_eop", {31'd0, wr_eop[0]}, 1);
        tick();
        checkOutput("G_done", {31'd0, done}, 1);
        checkOutput("G_lane_done", lane_done, 16'hFFFF);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
